// File: rtl/cfeb_readout_seq_if.sv
// cfeb_readout_seq_if: readout control, ADC/header inputs and sequencer outputs of the CFEB readout path
//   master: drives i_* (trigger logic, ADC bank, header sources); receives o_*
//   slave : the sequencer; receives i_*, drives o_*
//   i_push, i_xload, i_lastword, i_sendcheck, i_oecrc, i_ovlpint : readout control
//   i_data[15:0], i_k1adc..i_k6adc[12:0], i_l1anout[5:0], i_status[23:0] : word sources
//   o_scam150, o_adcclk, o_en50, o_dis50, o_scawrite : free-running frame strobes
//   o_oen_b[6:1], o_lpush_b, o_end, o_overlap, o_out[15:0] : ADC enables, FIFO side
interface cfeb_readout_seq_if;
    logic        i_push, i_xload, i_lastword, i_sendcheck, i_oecrc, i_ovlpint;
    logic [15:0] i_data;
    logic [12:0] i_k1adc, i_k2adc, i_k3adc, i_k4adc, i_k5adc, i_k6adc;
    logic [5:0]  i_l1anout;
    logic [23:0] i_status;
    logic        o_scam150, o_adcclk, o_en50, o_dis50, o_scawrite;
    logic        o_lpush_b, o_end, o_overlap;
    logic [6:1]  o_oen_b;
    logic [15:0] o_out;
    modport master (
        output i_push, i_xload, i_lastword, i_sendcheck, i_oecrc, i_ovlpint, i_data,
               i_k1adc, i_k2adc, i_k3adc, i_k4adc, i_k5adc, i_k6adc, i_l1anout, i_status,
        input  o_scam150, o_adcclk, o_en50, o_dis50, o_scawrite, o_lpush_b, o_end,
               o_overlap, o_oen_b, o_out
    );
    modport slave (
        input  i_push, i_xload, i_lastword, i_sendcheck, i_oecrc, i_ovlpint, i_data,
               i_k1adc, i_k2adc, i_k3adc, i_k4adc, i_k5adc, i_k6adc, i_l1anout, i_status,
        output o_scam150, o_adcclk, o_en50, o_dis50, o_scawrite, o_lpush_b, o_end,
               o_overlap, o_oen_b, o_out
    );
endinterface

// File: rtl/cfeb_readout_seq.sv
// cfeb_readout_seq: CFEB frame timing, ADC enable sequencing and 16-bit output mux with running CRC-16
//   i_clk   : 40 MHz clock, rising edge
//   i_rst_b : synchronous active-low reset
//   bus     : cfeb_readout_seq_if.slave (control, word sources, strobes, FIFO-side outputs)
module cfeb_readout_seq #(
    parameter int          NADC     = 6,
    parameter logic [15:0] CRC_POLY = 16'h8005
) (
    input logic               i_clk,
    input logic               i_rst_b,
    cfeb_readout_seq_if.slave bus
);
    function automatic logic [15:0] f_crc(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c ^ d;
        for (int i = 0; i < 16; i++) r = r[15] ? (r << 1) ^ CRC_POLY : r << 1;
        return r;
    endfunction
    logic [2:0]  r_ph;
    logic        r_scam, r_adcclk, r_en50, r_dis50, r_scaw;
    logic [6:1]  r_oen;
    logic        r_hx1, r_push1, r_sc1, r_oec1, r_fire1, r_pend;
    logic [1:0]  r_hn;
    logic [15:0] r_out, r_crc;
    logic        r_lpush_b, r_oec2, r_end, r_ovl;
    logic [2:0]  w_ph_nx;
    logic        w_hx, w_fire;
    logic [1:0]  w_hn_nx;
    logic [12:0] w_adc;
    logic [15:0] w_hdr, w_crc_nx, w_out_nx;
    always_comb begin
        w_ph_nx  = (r_ph == 3'(NADC - 1)) ? 3'd0 : r_ph + 3'd1;
        w_hx     = bus.i_push && bus.i_xload;
        // header index restarts on the rising edge of PUSH&XLOAD and saturates on the DATA slot
        w_hn_nx  = (w_hx && r_hx1) ? ((r_hn == 2'd3) ? 2'd3 : r_hn + 2'd1) : 2'd0;
        w_fire   = bus.i_sendcheck && (r_pend || bus.i_lastword);
        w_adc    = !r_oen[1] ? bus.i_k1adc : !r_oen[2] ? bus.i_k2adc : !r_oen[3] ? bus.i_k3adc :
                   !r_oen[4] ? bus.i_k4adc : !r_oen[5] ? bus.i_k5adc : bus.i_k6adc;
        w_hdr    = (r_hn == 2'd0) ? {10'h000, bus.i_l1anout} : (r_hn == 2'd1) ? bus.i_status[15:0] :
                   (r_hn == 2'd2) ? {8'h00, bus.i_status[23:16]} : bus.i_data;
        // the word now on OUT is folded in here, so a CRC slot right behind it already covers it
        w_crc_nx = r_oec2 ? 16'h0000 : !r_lpush_b ? f_crc(r_crc, r_out) : r_crc;
        w_out_nx = r_oec1 ? w_crc_nx : !(&r_oen) ? {3'b000, w_adc} : r_hx1 ? w_hdr : 16'h0000;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            r_ph      <= 3'd0;
            r_scam    <= 1'b1;
            r_adcclk  <= 1'b0;
            r_en50    <= 1'b1;
            r_dis50   <= 1'b0;
            r_scaw    <= 1'b0;
            r_oen     <= 6'h3F;
            r_hx1     <= 1'b0;
            r_hn      <= 2'd0;
            r_push1   <= 1'b0;
            r_sc1     <= 1'b0;
            r_oec1    <= 1'b0;
            r_fire1   <= 1'b0;
            r_pend    <= 1'b0;
            r_out     <= 16'h0000;
            r_lpush_b <= 1'b1;
            r_oec2    <= 1'b0;
            r_end     <= 1'b0;
            r_ovl     <= 1'b0;
            r_crc     <= 16'h0000;
        end else begin
            r_ph      <= w_ph_nx;
            r_scam    <= w_ph_nx < 3'd3;
            r_adcclk  <= w_ph_nx >= 3'd1 && w_ph_nx <= 3'd3;
            r_en50    <= w_ph_nx < 3'd2;
            r_dis50   <= w_ph_nx == 3'd3 || w_ph_nx == 3'd4;
            r_scaw    <= w_ph_nx == 3'd2;
            r_oen     <= (bus.i_push && !bus.i_xload) ? ~(6'b000001 << r_ph) : 6'h3F;
            r_hx1     <= w_hx;
            r_hn      <= w_hn_nx;
            r_push1   <= bus.i_push;
            r_sc1     <= bus.i_sendcheck;
            r_oec1    <= bus.i_oecrc;
            r_fire1   <= w_fire;
            r_pend    <= (r_pend || bus.i_lastword) && !bus.i_sendcheck;
            r_out     <= w_out_nx;
            r_lpush_b <= !(r_push1 || r_sc1);
            r_oec2    <= r_oec1;
            r_end     <= r_fire1;
            // a new overlap in the END cycle keeps the flag set
            r_ovl     <= bus.i_ovlpint || (r_ovl && !r_fire1);
            r_crc     <= w_crc_nx;
        end
    end
    assign bus.o_scam150 = r_scam;
    assign bus.o_adcclk  = r_adcclk;
    assign bus.o_en50    = r_en50;
    assign bus.o_dis50   = r_dis50;
    assign bus.o_scawrite = r_scaw;
    assign bus.o_oen_b   = r_oen;
    assign bus.o_out     = r_out;
    assign bus.o_lpush_b = r_lpush_b;
    assign bus.o_end     = r_end;
    assign bus.o_overlap = r_ovl;
endmodule

// File: tb/tb_cfeb_readout_seq.sv
// tb_cfeb_readout_seq: directed bench for cfeb_readout_seq with an expected-word scoreboard
`timescale 1ns/1ps
module tb_cfeb_readout_seq;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #12.5 clk = ~clk;
    cfeb_readout_seq_if bus ();
    cfeb_readout_seq dut (.i_clk(clk), .i_rst_b(rst_b), .bus(bus));
    typedef struct {int due; logic [15:0] val; logic en;} word_t;
    typedef struct {int due; logic [6:1] val;} oen_t;
    word_t qo[$];
    oen_t  qe[$];
    int tests = 0, fails = 0, cyc = 0, m_ph = 0, m_n = 0;
    logic m_hx = 1'b0, m_pend = 1'b0;
    logic [15:0] m_crc = 16'h0000;
    logic [12:0] kv [1:6];
    function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [15:0] d);
        logic fb;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        logic rs;
        logic [4:0] s;
        word_t w;
        oen_t e;
        rs = rst_b;
        @(posedge clk);
        #1;
        cyc++;
        if (!rs) begin
            m_ph = 0; m_n = 0; m_hx = 1'b0; m_pend = 1'b0; m_crc = 16'h0000;
            qo.delete(); qe.delete();
        end else m_ph = (m_ph + 1) % 6;
        s = {m_ph < 3, m_ph >= 1 && m_ph <= 3, m_ph < 2, m_ph == 3 || m_ph == 4, m_ph == 2};
        chk("strobes", {bus.o_scam150, bus.o_adcclk, bus.o_en50, bus.o_dis50, bus.o_scawrite}, s);
        if (qe.size() > 0 && qe[0].due == cyc) begin
            e = qe.pop_front();
            chk("oen_b", bus.o_oen_b, e.val);
        end else chk("oen_b_idle", bus.o_oen_b, 6'h3F);
        if (qo.size() > 0 && qo[0].due == cyc) begin
            w = qo.pop_front();
            chk("out", bus.o_out, w.val);
            chk("lpush_b", bus.o_lpush_b, 1'b0);
            chk("end", bus.o_end, w.en);
        end else chk("idle_out_lpush_end", {bus.o_lpush_b, bus.o_end, bus.o_out}, {1'b1, 1'b0, 16'h0000});
    endtask
    task automatic drive(input logic push, xload, lw, sc, oec, ovl);
        logic [5:0] one;
        logic [15:0] w;
        logic fire;
        bus.i_push = push; bus.i_xload = xload; bus.i_lastword = lw;
        bus.i_sendcheck = sc; bus.i_oecrc = oec; bus.i_ovlpint = ovl;
        one = 6'b000001 << m_ph;
        qe.push_back('{cyc + 1, (push && !xload) ? ~one : 6'h3F});
        if (push && xload) m_n = m_hx ? ((m_n == 3) ? 3 : m_n + 1) : 0;
        m_hx = push && xload;
        fire = sc && (m_pend || lw);
        m_pend = (m_pend || lw) && !sc;
        if (push || sc) begin
            if (oec) w = m_crc;
            else if (!xload) w = {3'b000, kv[m_ph + 1]};
            else if (m_n == 0) w = {10'h000, bus.i_l1anout};
            else if (m_n == 1) w = bus.i_status[15:0];
            else if (m_n == 2) w = {8'h00, bus.i_status[23:16]};
            else w = bus.i_data;
            m_crc = oec ? 16'h0000 : crc_bits(m_crc, w);
            qo.push_back('{cyc + 2, w, fire});
        end
        tick();
    endtask
    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0);
    endtask
    task automatic set_adc(input logic [7:0] ch);
        for (int k = 1; k <= 6; k++) kv[k] = {5'(k), ch};
        bus.i_k1adc = kv[1]; bus.i_k2adc = kv[2]; bus.i_k3adc = kv[3];
        bus.i_k4adc = kv[4]; bus.i_k5adc = kv[5]; bus.i_k6adc = kv[6];
    endtask
    initial begin
        bus.i_push = 0; bus.i_xload = 0; bus.i_lastword = 0; bus.i_sendcheck = 0;
        bus.i_oecrc = 0; bus.i_ovlpint = 0; bus.i_data = 16'h7FFF;
        bus.i_l1anout = 6'h15; bus.i_status = 24'hDEAD56;
        set_adc(8'h5A);
        idle(2);
        rst_b = 1'b1;
        idle(12);
        while (m_ph != 0) idle(1);
        repeat (96) drive(1, 0, 0, 0, 0, 0);
        idle(3);
        repeat (18) drive(1, 1, 0, 0, 0, 0);
        idle(3);
        drive(0, 0, 1, 0, 0, 0);
        idle(2);
        drive(0, 0, 0, 0, 0, 1);
        chk("overlap_set", bus.o_overlap, 1'b1);
        idle(2);
        drive(0, 0, 0, 1, 1, 0);
        chk("overlap_held", bus.o_overlap, 1'b1);
        idle(1);
        chk("overlap_cleared_by_end", bus.o_overlap, 1'b0);
        idle(2);
        drive(0, 0, 0, 1, 1, 0);
        idle(3);
        set_adc(8'hA5);
        while (m_ph != 3) idle(1);
        repeat (5) drive(1, 0, 0, 0, 0, 0);
        repeat (4) drive(1, 1, 0, 0, 0, 0);
        idle(3);
        drive(0, 0, 1, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        chk("overlap_set_with_end", bus.o_overlap, 1'b1);
        idle(3);
        repeat (4) drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0);
        rst_b = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        chk("overlap_reset", bus.o_overlap, 1'b0);
        rst_b = 1'b1;
        idle(2);
        drive(0, 0, 0, 1, 1, 0);
        idle(3);
        if (qo.size() != 0 || qe.size() != 0) chk("scoreboard_drained", qo.size() + qe.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cfeb_readout_seq.md
Name: cfeb_readout_seq

Overview:
- Single-clock readout sequencer and output multiplexer for the CFEB data path.
- Generates the 150 ns frame timing: a divide-by-6 phase on the 40 MHz clock, SCA/ADC strobes and one-hot ADC output enables.
- Multiplexes six 13-bit ADC words, a header (L1A number, status), pass-through data and a running CRC onto one 16-bit output.
- Drives the FIFO push strobe and the end-of-event marker.
- Sits between the ADC bank and the output FIFO.

Parameters:
- NADC, 6, number of ADC channels (fixed to 6; sets frame length in cycles).
- CRC_POLY, 16'h8005, CRC-16 polynomial (x^16+x^15+x^2+1).

Ports:
- CLK in 1: 40 MHz system clock (25 ns); all logic on rising edge.
- RST_B in 1: synchronous, active-low reset.
- PUSH in 1: readout active; one output word per cycle while high.
- XLOAD in 1: with PUSH, select header/DATA words instead of ADC words.
- LASTWORD in 1: marks the current event's final data block.
- SENDCHECK in 1: CRC word slot; pushes one extra word.
- OECRC in 1: output-enable for CRC onto OUT.
- OVLPINT in 1: overlap interrupt from trigger logic.
- DATA in 16: pass-through data word.
- K1ADC..K6ADC in 13 each: ADC conversion results.
- L1ANOUT in 6: L1A event number.
- STATUS in 24: status word.
- SCAM150 out 1: 150 ns SCA clock enable.
- ADCCLK out 1: ADC conversion strobe.
- EN50 out 1, DIS50 out 1: 50 ns window strobes.
- SCAWRITE out 1: SCA write pulse.
- OEN_B out 6 [6:1]: active-low one-hot ADC output enables.
- LPUSH_B out 1: active-low FIFO push.
- END out 1: end-of-event pulse.
- OVERLAP out 1: sticky overlap flag.
- OUT out 16: muxed output word.

Behaviour:
- Phase counter PH: 0..5, free-running, wraps 5->0; reset to 0. All outputs registered.
- Phase-decoded strobes:
  - SCAM150 = 1 in PH 0,1,2 (50% duty, 150 ns period).
  - ADCCLK = 1 in PH 1,2,3.
  - EN50 = 1 in PH 0,1; DIS50 = 1 in PH 3,4.
  - SCAWRITE = 1 in PH 2 only.
  - All strobes free-run, independent of PUSH.
- OEN_B (1-cycle latency):
  - Next cycle OEN_B = ~(1<<PH), i.e. OEN_B[PH+1]=0, when PUSH=1 and XLOAD=0; otherwise 6'b111111.
  - A PUSH starting mid-frame begins at the ADC of the current phase; no realignment.
- OUT (2-cycle latency from PUSH, valid the cycle after OEN_B), priority order:
  1. OECRC=1 -> OUT = CRC register.
  2. Else any OEN_B[k]=0 -> OUT = {3'b000, KkADC}.
  3. Else XLOAD=1 during PUSH -> header sequence indexed by n, the cycle count since PUSH&XLOAD rose:
     - n=0: {10'h000, L1ANOUT}
     - n=1: STATUS[15:0]
     - n=2: {8'h00, STATUS[23:16]}
     - n>=3: DATA
     - n saturates at 3.
  4. Else OUT = 16'h0000.
- LPUSH_B: low, aligned with OUT, for every cycle OUT carries an ADC, header/DATA or CRC word (PUSH or SENDCHECK delayed 2 cycles); otherwise high.
- CRC register:
  - CRC-16/CRC_POLY, parallel 16-bit update, initial 16'h0000.
  - Updated with OUT on every LPUSH_B-low cycle except CRC cycles.
  - Cleared the cycle after a CRC word is output.
- END:
  - LASTWORD=1 sets a pending flag.
  - END pulses 1 cycle, aligned with the CRC word slot (SENDCHECK delayed 2) while the flag is set; the flag clears with it.
  - A SENDCHECK without the flag produces no END.
- OVERLAP: set by OVLPINT=1; stays set until END or reset.
- Reset (RST_B=0 at clock edge): PH=0, OEN_B=6'h3F, OUT=0, LPUSH_B=1, END=0, OVERLAP=0, CRC=0, pending flag=0, n=0, all strobes at their PH=0 values. Reset mid-readout aborts immediately; there is no partial word.
- Simultaneous events:
  - OVLPINT with END: set wins, OVERLAP stays 1.
  - LASTWORD with SENDCHECK: END fires for this slot.

Test Plan:
- Release reset, idle 12 cycles -> SCAM150 pattern 111000 repeating; OEN_B=3F, OUT=0, LPUSH_B=1.
- PUSH high 96 cycles starting at PH=0, KkADC={k,ch} -> OEN_B cycles 3E,3D,3B,37,2F,1F ×16; OUT=0x0100+ch, 0x0200+ch, ..., 0x0600+ch; 96 LPUSH_B lows.
- PUSH=XLOAD=1 for 18 cycles, L1ANOUT=0x15, STATUS=0xDEAD56, DATA=0x7FFF -> OUT 0x0015, 0xAD56, 0x00DE, then 0x7FFF ×15; OEN_B stays 3F.
- LASTWORD pulse, then SENDCHECK/OECRC -> one CRC word equal to the software CRC-16 of the preceding words; END=1 that cycle; CRC=0 the next cycle.
- OVLPINT 1-cycle pulse -> OVERLAP=1 held until the next END, then 0.
- RST_B low mid-PUSH -> next cycle OEN_B=3F, OUT=0, PH=0, CRC=0.
